// File: rtl/astar_heuristic_eval_if.sv
// Request/result handshake bundle for the A* node evaluator.
interface astar_heuristic_eval_if #(
  parameter int unsigned COORD_W = 16,
  parameter int unsigned COST_W  = 32,
  parameter int unsigned TAG_W   = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         mode;
  logic [COST_W-1:0]  g;
  logic [COORD_W-1:0] x_curr;
  logic [COORD_W-1:0] y_curr;
  logic [COORD_W-1:0] x_goal;
  logic [COORD_W-1:0] y_goal;
  logic [TAG_W-1:0]   tag_in;
  logic               out_valid;
  logic               out_ready;
  logic [COST_W-1:0]  f;
  logic [COORD_W:0]   h;
  logic [TAG_W-1:0]   tag_out;
  logic               sat;
  logic               busy;

  // Requester / result consumer side.
  modport master (
    output in_valid, mode, g, x_curr, y_curr, x_goal, y_goal, tag_in, out_ready,
    input  in_ready, out_valid, f, h, tag_out, sat, busy
  );

  // Evaluator side.
  modport slave (
    input  in_valid, mode, g, x_curr, y_curr, x_goal, y_goal, tag_in, out_ready,
    output in_ready, out_valid, f, h, tag_out, sat, busy
  );
endinterface

// File: rtl/astar_heuristic_eval.sv
// A* node evaluator: f = g + h(curr, goal) with selectable heuristic
// (Manhattan, octile, floor-Euclidean via bit-serial sqrt, zero).
module astar_heuristic_eval #(
  parameter int unsigned COORD_W = 16,
  parameter int unsigned COST_W  = 32,
  parameter int unsigned TAG_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  astar_heuristic_eval_if.slave bus
);

  if (COST_W < COORD_W + 1) begin : g_width_check
    $error("astar_heuristic_eval: COST_W must be >= COORD_W+1");
  end

  localparam int unsigned SW    = 2 * COORD_W + 2;  // s padded to an even bit count
  localparam int unsigned RW    = COORD_W + 3;      // shifted remainder / trial width
  localparam int unsigned CNT_W = $clog2(COORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COORD_W);

  typedef enum logic [2:0] {IDLE, HEUR, SQRT, SUM, OUT} state_t;

  state_t state_q, state_d;

  logic [COORD_W-1:0] dx_q, dy_q;
  logic [COST_W-1:0]  g_q;
  logic [1:0]         mode_q;
  logic [TAG_W-1:0]   tag_q;
  logic [COORD_W:0]   h_q;
  logic [SW-1:0]      s_q;
  logic [COORD_W:0]   rem_q;
  logic [COORD_W:0]   root_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [COST_W-1:0]  f_q;
  logic [COORD_W:0]   h_out_q;
  logic [TAG_W-1:0]   tag_out_q;
  logic               sat_q;

  logic [COORD_W-1:0] dx_in, dy_in, mn, mx;
  logic [COORD_W+6:0] oct_prod;
  logic [COORD_W:0]   manh_h, oct_h;
  logic [SW-1:0]      sq;
  logic [RW-1:0]      rem_sh, trial, rem_diff;
  logic               take;
  logic [COORD_W:0]   rem_next, root_next;
  logic [COST_W:0]    sum;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid)           state_d = HEUR;
      HEUR: state_d = (mode_q == 2'd2) ? SQRT : SUM;
      SQRT: if (cnt_q == CNT_LAST)      state_d = SUM;
      SUM:  state_d = OUT;
      OUT:  if (bus.out_ready)          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Heuristic arithmetic, one sqrt step, and the saturating sum.
  always_comb begin
    dx_in = (bus.x_curr >= bus.x_goal) ? bus.x_curr - bus.x_goal : bus.x_goal - bus.x_curr;
    dy_in = (bus.y_curr >= bus.y_goal) ? bus.y_curr - bus.y_goal : bus.y_goal - bus.y_curr;
    mn = (dx_q < dy_q) ? dx_q : dy_q;
    mx = (dx_q < dy_q) ? dy_q : dx_q;
    manh_h = (COORD_W+1)'(dx_q) + (COORD_W+1)'(dy_q);
    oct_prod = (COORD_W+7)'(mn) * (COORD_W+7)'(106);
    oct_h = (COORD_W+1)'(mx) + (COORD_W+1)'(oct_prod[COORD_W+6:8]);
    sq = SW'(dx_q) * SW'(dx_q) + SW'(dy_q) * SW'(dy_q);
    // Restoring step: bring down two radicand bits, try subtracting 4*root+1.
    rem_sh    = {rem_q, s_q[SW-1 -: 2]};
    trial     = {root_q, 2'b01};
    take      = (rem_sh >= trial);
    rem_diff  = take ? rem_sh - trial : rem_sh;
    rem_next  = (COORD_W+1)'(rem_diff);
    root_next = {root_q[COORD_W-1:0], take};
    sum = (COST_W+1)'(g_q) + (COST_W+1)'(h_q);
  end

  // Datapath registers: capture on accept, evaluate, publish at SUM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx_q <= '0; dy_q <= '0; g_q <= '0; mode_q <= '0; tag_q <= '0;
      h_q <= '0; s_q <= '0; rem_q <= '0; root_q <= '0; cnt_q <= '0;
      f_q <= '0; h_out_q <= '0; tag_out_q <= '0; sat_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.in_valid) begin
          dx_q   <= dx_in;
          dy_q   <= dy_in;
          g_q    <= bus.g;
          mode_q <= bus.mode;
          tag_q  <= bus.tag_in;
        end
        HEUR: begin
          unique case (mode_q)
            2'd0:    h_q <= manh_h;
            2'd1:    h_q <= oct_h;
            default: h_q <= '0;
          endcase
          s_q    <= sq;
          rem_q  <= '0;
          root_q <= '0;
          cnt_q  <= '0;
        end
        SQRT: begin
          s_q    <= s_q << 2;
          rem_q  <= rem_next;
          root_q <= root_next;
          h_q    <= root_next;
          cnt_q  <= cnt_q + 1'b1;
        end
        SUM: begin
          f_q       <= sum[COST_W] ? '1 : sum[COST_W-1:0];
          sat_q     <= sum[COST_W];
          h_out_q   <= h_q;
          tag_out_q <= tag_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.busy      = (state_q != IDLE);
  assign bus.f         = f_q;
  assign bus.h         = h_out_q;
  assign bus.tag_out   = tag_out_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_astar_heuristic_eval.sv
// Randomised + directed bench for astar_heuristic_eval against an arithmetic model.
module tb_astar_heuristic_eval;
  localparam int unsigned COORD_W = 16;
  localparam int unsigned COST_W  = 32;
  localparam int unsigned TAG_W   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  astar_heuristic_eval_if #(.COORD_W(COORD_W), .COST_W(COST_W), .TAG_W(TAG_W)) bus ();

  astar_heuristic_eval #(.COORD_W(COORD_W), .COST_W(COST_W), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint isqrt(input longint s);
    longint r;
    r = longint'($sqrt(real'(s)));
    while (r * r > s) r--;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  function automatic longint ref_h(input int m, input longint xc, input longint yc,
                                   input longint xg, input longint yg);
    longint dx, dy, lo, hi;
    dx = (xc > xg) ? xc - xg : xg - xc;
    dy = (yc > yg) ? yc - yg : yg - yc;
    lo = (dx < dy) ? dx : dy;
    hi = (dx < dy) ? dy : dx;
    case (m)
      0: return dx + dy;
      1: return hi + (lo * 106) / 256;
      2: return isqrt(dx * dx + dy * dy);
      default: return 0;
    endcase
  endfunction

  task automatic scramble_inputs();
    bus.mode   = 2'($urandom);
    bus.g      = $urandom;
    bus.x_curr = 16'($urandom);
    bus.y_curr = 16'($urandom);
    bus.x_goal = 16'($urandom);
    bus.y_goal = 16'($urandom);
    bus.tag_in = 8'($urandom);
  endtask

  // Drive one request, wait for it, check outputs, stall, then hand off.
  task automatic do_req(input int m, input longint gg, input longint xc, input longint yc,
                        input longint xg, input longint yg, input int tg, input int stall);
    longint eh, sum, ef, esat;
    int n, lat;
    eh   = ref_h(m, xc, yc, xg, yg);
    sum  = gg + eh;
    esat = (sum > 64'hFFFF_FFFF) ? 1 : 0;
    ef   = esat ? 64'hFFFF_FFFF : sum;

    @(negedge clk);
    bus.mode = 2'(m); bus.g = 32'(gg);
    bus.x_curr = 16'(xc); bus.y_curr = 16'(yc);
    bus.x_goal = 16'(xg); bus.y_goal = 16'(yg);
    bus.tag_in = 8'(tg); bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    check("accept_wait", longint'(n < 200), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    scramble_inputs();
    lat = 0;
    while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    check("latency", lat, (m == 2) ? COORD_W + 3 : 2);
    check("h", bus.h, eh);
    check("f", bus.f, ef);
    check("sat", bus.sat, esat);
    check("tag_out", bus.tag_out, tg);
    check("busy_out", bus.busy, 1);
    check("in_ready_out", bus.in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'(i % 2);
      @(posedge clk); #1;
      check("stall_valid", bus.out_valid, 1);
      check("stall_f", bus.f, ef);
      check("stall_h", bus.h, eh);
      check("stall_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("post_valid", bus.out_valid, 0);
    check("post_in_ready", bus.in_ready, 1);
    check("post_f_hold", bus.f, ef);
    check("post_tag_hold", bus.tag_out, tg);
  endtask

  function automatic longint rnd_coord();
    int k;
    k = $urandom_range(0, 7);
    if (k == 0) return 0;
    if (k == 1) return 16'hFFFF;
    return longint'($urandom_range(0, 16'hFFFF));
  endfunction

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    scramble_inputs();
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_f", bus.f, 0);
    check("rst_h", bus.h, 0);
    check("rst_tag", bus.tag_out, 0);
    check("rst_sat", bus.sat, 0);
    check("rst_busy", bus.busy, 0);
    @(negedge clk); rst = 1'b0;

    // Directed cases.
    do_req(0, 10, 3, 4, 0, 0, 8'h5A, 0);
    do_req(1, 0, 3, 4, 0, 0, 1, 0);
    do_req(2, 0, 3, 4, 0, 0, 2, 0);
    do_req(2, 7, 0, 0, 16'hFFFF, 16'hFFFF, 3, 0);
    do_req(3, 1234, 9, 100, 500, 2, 4, 0);
    do_req(0, 0, 2, 9, 7, 1, 5, 0);
    for (int m = 0; m < 4; m++) do_req(m, 50, 321, 321, 321, 321, 6 + m, 0);
    do_req(0, 64'hFFFF_FFFE, 5, 0, 0, 0, 10, 0);
    do_req(0, 64'hFFFF_FFFA, 5, 0, 0, 0, 11, 0);
    do_req(1, 99, 100, 7, 0, 50, 12, 10);

    // Reset in the middle of the square root.
    @(negedge clk);
    bus.mode = 2'd2; bus.g = 32'd1; bus.x_curr = 16'd300; bus.y_curr = 16'd400;
    bus.x_goal = 16'd0; bus.y_goal = 16'd0; bus.tag_in = 8'h77; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_f", bus.f, 0);
    @(negedge clk); rst = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      check("aborted_no_valid", bus.out_valid, 0);
    end
    do_req(2, 1, 300, 400, 0, 0, 8'h78, 0);

    // Random sweep.
    for (int i = 0; i < 60; i++) begin
      longint gg;
      case ($urandom_range(0, 3))
        0: gg = 64'hFFFF_FFFF - longint'($urandom_range(0, 70000));
        1: gg = longint'($urandom_range(0, 100));
        default: gg = longint'($urandom);
      endcase
      do_req(int'($urandom_range(0, 3)), gg, rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord(),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
